// File: rtl/mastermind_breaker_if.sv
// Guess/feedback channel between the code-breaker (master) and the code-setter/compare path (slave).
interface mastermind_breaker_if;
  logic [11:0] guess_out;
  logic        guess_valid;
  logic        guess_ack;
  logic        fb_valid;
  logic [2:0]  fb_red;
  logic [2:0]  fb_white;

  modport master (output guess_out, guess_valid, input guess_ack, fb_valid, fb_red, fb_white);
  modport slave  (input guess_out, guess_valid, output guess_ack, fb_valid, fb_red, fb_white);
endinterface

// File: rtl/mastermind_breaker.sv
// Mastermind code-breaker: proposes the lowest-ordered code consistent with every
// red/white feedback received so far, one history comparison per clock.
module mastermind_breaker #(
  parameter int          NUM_COLOURS = 8,
  parameter int          MAX_GUESSES = 8,
  parameter logic [11:0] FIRST_GUESS = 12'o1100
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  mastermind_breaker_if.master        bus,
  output logic                        busy,
  output logic                        solved,
  output logic                        failed,
  output logic                        error,
  output logic [3:0]                  guess_count
);

  localparam logic [3:0] NC4  = 4'(NUM_COLOURS);
  localparam logic [3:0] MAXG = 4'(MAX_GUESSES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROPOSE = 3'd1,
    WAIT_FB = 3'd2,
    SEARCH  = 3'd3,
    SOLVED  = 3'd4,
    FAILED  = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [11:0] guess_r, guess_s;
  logic [12:0] cand_r, cand_s;
  logic [3:0]  idx_r, idx_s;
  logic [3:0]  count_r, count_s;
  logic        error_r, error_s;
  logic        valid_r, busy_r, solved_r, failed_r;
  logic        hist_we_s, hist_clr_s;
  logic [5:0]  sc_s;
  logic [11:0] hist_code_r  [16];
  logic [2:0]  hist_red_r   [16];
  logic [2:0]  hist_white_r [16];

  function automatic logic [5:0] score(input logic [11:0] a, input logic [11:0] b);
    logic [2:0] red;
    logic [2:0] common;
    logic [2:0] ca;
    logic [2:0] cb;
    red    = 3'd0;
    common = 3'd0;
    for (int p = 0; p < 4; p++) begin
      red = red + ((a[3*p +: 3] == b[3*p +: 3]) ? 3'd1 : 3'd0);
    end
    for (int c = 0; c < 8; c++) begin
      ca = 3'd0;
      cb = 3'd0;
      for (int p = 0; p < 4; p++) begin
        ca = ca + ((a[3*p +: 3] == 3'(c)) ? 3'd1 : 3'd0);
        cb = cb + ((b[3*p +: 3] == 3'(c)) ? 3'd1 : 3'd0);
      end
      common = common + ((ca < cb) ? ca : cb);
    end
    return {red, 3'(common - red)};
  endfunction

  function automatic logic legal(input logic [11:0] c);
    logic ok;
    ok = 1'b1;
    for (int p = 0; p < 4; p++) begin
      ok = ok & ({1'b0, c[3*p +: 3]} < NC4);
    end
    return ok;
  endfunction

  // Next-state, candidate sweep and history-write decode.
  always_comb begin
    state_s    = state_r;
    guess_s    = guess_r;
    cand_s     = cand_r;
    idx_s      = idx_r;
    count_s    = count_r;
    error_s    = error_r;
    hist_we_s  = 1'b0;
    hist_clr_s = 1'b0;
    sc_s       = score(cand_r[11:0], hist_code_r[idx_r]);
    case (state_r)
      IDLE, SOLVED, FAILED: begin
        if (start) begin
          state_s    = PROPOSE;
          guess_s    = FIRST_GUESS;
          count_s    = 4'd0;
          error_s    = 1'b0;
          cand_s     = 13'd0;
          idx_s      = 4'd0;
          hist_clr_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      PROPOSE: begin
        if (bus.guess_ack) begin
          count_s = count_r + 4'd1;
          state_s = WAIT_FB;
        end else begin
          state_s = PROPOSE;
        end
      end
      WAIT_FB: begin
        if (!bus.fb_valid) begin
          state_s = WAIT_FB;
        end else if ((({1'b0, bus.fb_red} + {1'b0, bus.fb_white}) > 4'd4) ||
                     ((bus.fb_red == 3'd3) && (bus.fb_white == 3'd1))) begin
          state_s = FAILED;
          error_s = 1'b1;
        end else if (bus.fb_red == 3'd4) begin
          state_s = SOLVED;
        end else if (count_r == MAXG) begin
          state_s = FAILED;
          error_s = 1'b0;
        end else begin
          // Lower candidates were already excluded by the previous sweep.
          hist_we_s = 1'b1;
          state_s   = SEARCH;
          idx_s     = 4'd0;
          cand_s    = (count_r == 4'd1) ? 13'd0 : ({1'b0, guess_r} + 13'd1);
        end
      end
      SEARCH: begin
        if (cand_r[12]) begin
          state_s = FAILED;
          error_s = 1'b1;
        end else if (!legal(cand_r[11:0]) ||
                     (sc_s != {hist_red_r[idx_r], hist_white_r[idx_r]})) begin
          if (cand_r[11:0] == 12'o7777) begin
            state_s = FAILED;
            error_s = 1'b1;
          end else begin
            cand_s = cand_r + 13'd1;
            idx_s  = 4'd0;
          end
        end else if (idx_r == (count_r - 4'd1)) begin
          guess_s = cand_r[11:0];
          state_s = PROPOSE;
        end else begin
          idx_s = idx_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath, history and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= IDLE;
      guess_r  <= 12'd0;
      cand_r   <= 13'd0;
      idx_r    <= 4'd0;
      count_r  <= 4'd0;
      error_r  <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      solved_r <= 1'b0;
      failed_r <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        hist_code_r[i]  <= 12'd0;
        hist_red_r[i]   <= 3'd0;
        hist_white_r[i] <= 3'd0;
      end
    end else begin
      state_r  <= state_s;
      guess_r  <= guess_s;
      cand_r   <= cand_s;
      idx_r    <= idx_s;
      count_r  <= count_s;
      error_r  <= error_s;
      valid_r  <= (state_s == PROPOSE);
      busy_r   <= (state_s == PROPOSE) || (state_s == WAIT_FB) || (state_s == SEARCH);
      solved_r <= (state_s == SOLVED);
      failed_r <= (state_s == FAILED);
      if (hist_clr_s) begin
        for (int i = 0; i < 16; i++) begin
          hist_code_r[i]  <= 12'd0;
          hist_red_r[i]   <= 3'd0;
          hist_white_r[i] <= 3'd0;
        end
      end else if (hist_we_s) begin
        hist_code_r[count_r - 4'd1]  <= guess_r;
        hist_red_r[count_r - 4'd1]   <= bus.fb_red;
        hist_white_r[count_r - 4'd1] <= bus.fb_white;
      end else begin
        hist_code_r[0] <= hist_code_r[0];
      end
    end
  end

  assign bus.guess_out   = guess_r;
  assign bus.guess_valid = valid_r;
  assign busy            = busy_r;
  assign solved          = solved_r;
  assign failed          = failed_r;
  assign error           = error_r;
  assign guess_count     = count_r;

endmodule

// File: tb/tb_mastermind_breaker.sv
// Bench for mastermind_breaker: three parameterisations, directed handshake/reset steps
// and random games checked against a brute-force consistency model.
module tb_mastermind_breaker;
  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn   [ND];
  logic        start  [ND];
  logic        ack    [ND];
  logic        fbv    [ND];
  logic [2:0]  fbr    [ND];
  logic [2:0]  fbw    [ND];
  logic [11:0] gout   [ND];
  logic        gval   [ND];
  logic        busy   [ND];
  logic        solved [ND];
  logic        failed [ND];
  logic        error  [ND];
  logic [3:0]  gcnt   [ND];

  // d0: defaults, d1: MAX_GUESSES=2, d2: NUM_COLOURS=2
  for (genvar g = 0; g < ND; g++) begin : gd
    mastermind_breaker_if bus_i ();
    assign bus_i.guess_ack = ack[g];
    assign bus_i.fb_valid  = fbv[g];
    assign bus_i.fb_red    = fbr[g];
    assign bus_i.fb_white  = fbw[g];
    assign gout[g]         = bus_i.guess_out;
    assign gval[g]         = bus_i.guess_valid;
    mastermind_breaker #(
      .NUM_COLOURS((g == 2) ? 2 : 8),
      .MAX_GUESSES((g == 1) ? 2 : 8),
      .FIRST_GUESS(12'o1100)
    ) dut (
      .clk(clk), .resetn(rstn[g]), .start(start[g]), .bus(bus_i),
      .busy(busy[g]), .solved(solved[g]), .failed(failed[g]), .error(error[g]),
      .guess_count(gcnt[g])
    );
  end

  int tests = 0;
  int fails = 0;
  int hc[$];
  int hr[$];
  int hw[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int peg(input int code, input int p);
    return (code >> (3 * p)) & 7;
  endfunction

  // Mastermind score from colour counts: returns red*8 + white.
  function automatic int ref_score(input int a, input int b);
    int na[8];
    int nb[8];
    int red;
    int common;
    red = 0;
    common = 0;
    for (int c = 0; c < 8; c++) begin na[c] = 0; nb[c] = 0; end
    for (int p = 0; p < 4; p++) begin
      na[peg(a, p)]++;
      nb[peg(b, p)]++;
      if (peg(a, p) == peg(b, p)) red++;
    end
    for (int c = 0; c < 8; c++) common += (na[c] < nb[c]) ? na[c] : nb[c];
    return red * 8 + (common - red);
  endfunction

  // Lowest legal code >= from consistent with history, and the comparisons spent finding it.
  function automatic void model_search(input int from, input int ncol,
                                       output int found, output int guess, output int cycles);
    int k;
    int ok;
    found = 0; guess = 0; cycles = 0;
    for (int c = from; c < 4096; c++) begin
      ok = 1;
      for (int p = 0; p < 4; p++) if (peg(c, p) >= ncol) ok = 0;
      if (ok == 0) begin
        cycles++;
      end else begin
        for (k = 0; k < hc.size(); k++) begin
          cycles++;
          if (ref_score(c, hc[k]) != hr[k] * 8 + hw[k]) break;
        end
        if (k == hc.size()) begin
          found = 1;
          guess = c;
          return;
        end
      end
    end
  endfunction

  task automatic pulse_start(input int d);
    start[d] = 1'b1; @(negedge clk); start[d] = 1'b0;
  endtask

  task automatic ack_guess(input int d);
    ack[d] = 1'b1; @(negedge clk); ack[d] = 1'b0;
  endtask

  task automatic give_fb(input int d, input int r, input int w);
    fbv[d] = 1'b1; fbr[d] = 3'(r); fbw[d] = 3'(w);
    @(negedge clk);
    fbv[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int budget, output int n);
    n = 0;
    while (!gval[d] && n < budget) begin @(negedge clk); n++; end
    check("valid_within_budget", gval[d], 1'b1);
  endtask

  task automatic wait_failed(input int d, input int budget);
    int n;
    n = 0;
    while (!failed[d] && n < budget) begin @(negedge clk); n++; end
    check("failed_within_budget", failed[d], 1'b1);
  endtask

  task automatic check_idle_outputs(input int d);
    check("rst_guess_out", gout[d], 12'd0);
    check("rst_guess_valid", gval[d], 1'b0);
    check("rst_busy", busy[d], 1'b0);
    check("rst_solved", solved[d], 1'b0);
    check("rst_failed", failed[d], 1'b0);
    check("rst_error", error[d], 1'b0);
    check("rst_count", gcnt[d], 4'd0);
  endtask

  task automatic play_game(input int d, input int secret, input int ncol, input int maxg);
    int lat, found, g, cyc, fb, expg;
    hc.delete(); hr.delete(); hw.delete();
    pulse_start(d);
    check("start_to_valid", gval[d], 1'b1);
    expg = 12'o1100;
    for (int k = 1; k <= maxg; k++) begin
      check("guess_out", gout[d], expg);
      check("count_before_ack", gcnt[d], k - 1);
      fb = ref_score(secret, expg);
      ack_guess(d);
      check("valid_drops_after_ack", gval[d], 1'b0);
      give_fb(d, fb / 8, fb % 8);
      if (fb / 8 == 4) begin
        check("solved", solved[d], 1'b1);
        check("solved_failed", failed[d], 1'b0);
        check("solved_busy", busy[d], 1'b0);
        check("solved_count", gcnt[d], k);
        return;
      end
      if (k == maxg) begin
        check("budget_failed", failed[d], 1'b1);
        check("budget_error", error[d], 1'b0);
        check("budget_count", gcnt[d], k);
        return;
      end
      hc.push_back(expg); hr.push_back(fb / 8); hw.push_back(fb % 8);
      model_search((k == 1) ? 0 : expg + 1, ncol, found, g, cyc);
      if (found == 0) begin
        wait_failed(d, 6000);
        check("exhaust_error", error[d], 1'b1);
        check("exhaust_valid", gval[d], 1'b0);
        return;
      end
      wait_valid(d, cyc + 4, lat);
      check("fb_to_valid_latency", lat + 1, cyc + 1);
      expg = g;
    end
  endtask

  initial begin
    int seen;
    for (int d = 0; d < ND; d++) begin
      rstn[d] = 1'b0; start[d] = 1'b0; ack[d] = 1'b0;
      fbv[d] = 1'b0; fbr[d] = 3'd0; fbw[d] = 3'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) check_idle_outputs(d);
    for (int d = 0; d < ND; d++) rstn[d] = 1'b1;
    @(negedge clk);

    // First guess is the secret.
    play_game(0, 12'o1100, 8, 8);
    // One search cycle to reach 0000.
    play_game(0, 12'o0000, 8, 8);

    // Stalled handshake, start while busy, feedback during PROPOSE.
    pulse_start(0);
    for (int i = 0; i < 5; i++) begin
      start[0] = (i == 1); fbv[0] = (i == 3); fbr[0] = 3'd4; fbw[0] = 3'd0;
      @(negedge clk);
      check("stall_valid", gval[0], 1'b1);
      check("stall_guess", gout[0], 12'o1100);
      check("stall_solved", solved[0], 1'b0);
      check("stall_count", gcnt[0], 4'd0);
    end
    start[0] = 1'b0; fbv[0] = 1'b0;
    ack[0] = 1'b1; fbv[0] = 1'b1; fbr[0] = 3'd4;
    @(negedge clk);
    ack[0] = 1'b0; fbv[0] = 1'b0;
    @(negedge clk);
    check("ack_fb_same_cycle_solved", solved[0], 1'b0);
    check("ack_fb_same_cycle_busy", busy[0], 1'b1);
    check("ack_fb_same_cycle_count", gcnt[0], 4'd1);
    give_fb(0, 4, 0);
    check("late_fb_solved", solved[0], 1'b1);

    // Illegal (3,1) feedback.
    pulse_start(0);
    ack_guess(0);
    give_fb(0, 3, 1);
    check("illegal_fb_failed", failed[0], 1'b1);
    check("illegal_fb_error", error[0], 1'b1);
    check("illegal_fb_busy", busy[0], 1'b0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); seen |= int'(gval[0]); end
    check("illegal_fb_no_valid", seen, 0);

    for (int i = 0; i < 3; i++) play_game(0, int'($urandom_range(4095, 0)), 8, 8);

    // Budget exhaustion with MAX_GUESSES=2 (second guess 2222).
    play_game(1, 12'o7777, 8, 2);

    // Reset mid-search on the 2-colour instance, then a full exhaustive sweep.
    pulse_start(2);
    ack_guess(2);
    give_fb(2, 0, 0);
    repeat (10) @(negedge clk);
    check("mid_search_busy", busy[2], 1'b1);
    pulse_start(2);
    check("busy_start_count", gcnt[2], 4'd1);
    check("busy_start_valid", gval[2], 1'b0);
    rstn[2] = 1'b0;
    @(negedge clk);
    check_idle_outputs(2);
    rstn[2] = 1'b1;
    @(negedge clk);
    play_game(2, 12'o2222, 2, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mastermind_breaker.md
Name: mastermind_breaker

Overview:
- Automatic code-breaker: the guessing end of the Mastermind game.
- Emits 4-peg guesses over a valid/ack handshake and consumes red/white feedback from the existing code-setter/compare path.
- Picks each next guess as the lowest-ordered candidate consistent with all feedback so far.
- Reports solved, failed or error.

Parameters:
- NUM_COLOURS, 8, legal peg values 0..NUM_COLOURS-1; range 2..8.
- MAX_GUESSES, 8, guess budget; range 1..15.
- FIRST_GUESS, 12'o1100, opening guess; peg1=[2:0], peg2=[5:3], peg3=[8:6], peg4=[11:9].

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  begin a new game; honoured only in IDLE/SOLVED/FAILED
- guess_out  out  12  proposed guess, same peg packing as the code register
- guess_valid  out  1  guess_out is valid
- guess_ack  in  1  consumer accepted guess_out
- fb_valid  in  1  feedback strobe
- fb_red  in  3  exact-position matches
- fb_white  in  3  colour-only matches
- busy  out  1  high in every state except IDLE/SOLVED/FAILED
- solved  out  1  level, high in SOLVED
- failed  out  1  level, high in FAILED
- error  out  1  level, high in FAILED when the cause is illegal or inconsistent feedback
- guess_count  out  4  guesses accepted this game

Behaviour:
- Reset, or resetn low mid-operation, has a 1-cycle effect:
  - state to IDLE; all outputs 0; guess_out 12'd0; history cleared; candidate register 0.
- States and transitions:
  - IDLE: start -> PROPOSE with guess_out=FIRST_GUESS; history and count cleared.
  - PROPOSE: guess_valid=1; guess_out held stable until guess_ack is sampled high; then guess_count+1 -> WAIT_FB. guess_valid may be 1 in the same cycle it is acked.
  - WAIT_FB: ignore everything until fb_valid is high, then:
    - fb_red+fb_white>4, or (fb_red==3 && fb_white==1) -> FAILED, error=1.
    - fb_red==4 -> SOLVED.
    - guess_count==MAX_GUESSES -> FAILED, error=0.
    - otherwise store {guess_out, fb_red, fb_white} at history[guess_count-1] -> SEARCH.
  - SEARCH: the candidate register starts at 0 after the first feedback; later searches resume at the last proposed candidate+1, because lower candidates are already excluded.
    - Each cycle, exactly one of:
      - candidate has any peg >= NUM_COLOURS: skip to candidate+1, index=0.
      - score(candidate, history[index]) != stored feedback: candidate+1, index=0.
      - match and index==entries-1: guess_out=candidate -> PROPOSE.
      - match otherwise: index+1.
    - Incrementing past 12'o7777 -> FAILED, error=1 (no consistent code remains).
  - SOLVED/FAILED: hold outputs and guess_count; start -> new game as from IDLE.
- Scoring (combinational, one pair per cycle):
  - red = number of positions with equal pegs.
  - white = sum over colours c of min(count_c(a), count_c(b)), minus red.
  - All 3-bit unsigned; no overflow is possible.
- A previously guessed code never re-qualifies: its self-score (4,0) differs from its stored feedback.
- Ignored inputs:
  - start while busy.
  - fb_valid outside WAIT_FB.
  - guess_ack outside PROPOSE.
- Simultaneous guess_ack and fb_valid in PROPOSE: only the ack is taken; fb_valid is not sampled until the next cycle.
- Latency:
  - feedback to next guess_valid = 1 + number of SEARCH cycles; minimum 1 SEARCH cycle with one history entry.
  - start to guess_valid = 1 cycle.

Test Plan:
- Secret = 12'o1100; ack guess 1, return (4,0) -> solved=1, guess_count=1, failed=0, busy=0.
- Secret = 12'o0000, defaults; guess 12'o1100, return (2,0) -> exactly 1 SEARCH cycle, then guess_out=12'o0000; return (4,0) -> solved=1, guess_count=2.
- MAX_GUESSES=2, always return (0,0) -> guess 2 = 12'o2222; after 2nd feedback failed=1, error=0, guess_count=2.
- Return (3,1) to guess 1 -> failed=1, error=1, no further guess_valid.
- NUM_COLOURS=2, return (0,0) to 12'o1100 -> sweep exhausts at 12'o7777 -> failed=1, error=1.
- Handshake and reset:
  - hold guess_ack low 5 cycles -> guess_out stable, guess_valid=1.
  - fb_valid while in PROPOSE is ignored.
  - resetn low mid-SEARCH -> next cycle all outputs 0, state IDLE.
  - start while busy has no effect.
